difficulty_select: RTL and testbench
====================================

DIFFICULTY_SELECT -- requirements
Module: difficulty_select

Interface
REQ-001 Parameter PERIOD1, default 16, tick period in clock cycles at level 1; SHALL be a power of two ≥ 8.
REQ-002 Port clk  input  1  single system clock; all state SHALL update on its rising edge.
REQ-003 Port reset  input  1  synchronous, active-high reset.
REQ-004 Port key_up  input  1  raw active-high button level, asynchronous to clk.
REQ-005 Port key_down  input  1  raw active-high button level, asynchronous to clk.
REQ-006 Port start  input  1  single-cycle pulse from game control requesting play.
REQ-007 Port game_over  input  1  single-cycle pulse from game control ending play.
REQ-008 Port level_up  input  1  single-cycle pulse from score logic requesting auto-advance.
REQ-009 Port diff  output  3  difficulty code feeding the 7-segment difficulty display.
REQ-010 Port tick  output  1  one-cycle game-speed strobe.
REQ-011 Port playing  output  1  high while in PLAY.

Function
REQ-012 Level range 1..4; diff SHALL be thermometer-coded: L1=000, L2=001, L3=011, L4=111. No other diff value SHALL ever be driven.
REQ-013 Each key SHALL pass through a two-flop synchroniser, then a previous-value register; press = sync2 & ~prev.
REQ-014 Press latency: key high before edge n -> press high during cycle after edge n+2 -> diff updated at edge n+3.
REQ-015 Holding a key SHALL produce exactly one step; a further step needs release (≥ 1 sampled low) and re-press.
REQ-016 Up press SHALL increment level, saturating at L4; down press SHALL decrement, saturating at L1.
REQ-017 Simultaneous up and down presses in the same cycle SHALL leave the level unchanged.
REQ-018 FSM states: IDLE, PLAY, OVER; playing = (state == PLAY).
REQ-019 IDLE: key presses adjust level; start -> PLAY at next edge, tick counter cleared to 0; level_up ignored.
REQ-020 PLAY: key presses ignored (synchroniser and edge registers keep running); level_up increments level, saturating at L4.
REQ-021 PLAY: game_over -> OVER at next edge; if game_over and level_up coincide, game_over wins and level is unchanged.
REQ-022 OVER: diff held, tick held 0; any key press or start -> IDLE at next edge, level retained.
REQ-023 start in PLAY or OVER (other than the OVER exit) and game_over in IDLE or OVER SHALL be ignored.
REQ-024 Tick period P = PERIOD1 >> (level-1). Counter width = log2(PERIOD1).
REQ-025 Counter runs only in PLAY, counting 0..P-1. tick SHALL be registered and high for exactly the one cycle after the counter reaches P-1; counter wraps to 0.
REQ-026 A level change in PLAY SHALL clear the counter at the edge the level changes; the new P applies from the next count.
REQ-027 Outside PLAY, the counter SHALL be held at 0 and tick SHALL be 0.

Reset
REQ-028 While reset is high at an edge: state=IDLE, level=L1 (diff=000), counter=0, tick=0, playing=0, all synchroniser and edge registers = 0.
REQ-029 Reset SHALL override every other input in the same cycle, including mid-PLAY and mid-press; a key still held when reset releases SHALL register as a new press once its synchronised value is high.

Verification
REQ-030 After reset, hold key_up for 10 cycles -> diff=001 exactly 3 edges after the first sampled high, no further change; release/re-press ×3 -> 011, 111, 111.
REQ-031 From L2, assert key_up and key_down on the same edge for 5 cycles -> diff stays 001; then four down presses -> 000 with no underflow.
REQ-032 PERIOD1=16, L1, pulse start -> playing=1 next edge; tick pulses every 16 cycles; key presses during PLAY leave diff=000.
REQ-033 In PLAY at L1, pulse level_up three times then twice more -> diff 001, 011, 111, 111; tick spacing 8, then 4, then 2 cycles, counter restarting at each change.
REQ-034 In PLAY, pulse game_over and level_up together -> OVER, diff unchanged, tick=0; then a key press -> IDLE with level retained.
REQ-035 Assert reset mid-PLAY at L3 -> next edge diff=000, playing=0, tick=0; start then restores 16-cycle ticking.

Source files
------------

// File: rtl/difficulty_select_if.sv
// Bundle of game-control, key and display signals around the difficulty selector.
// The game side (master) drives keys and control pulses; the selector (slave)
// returns the difficulty code, the speed strobe and the play flag.
interface difficulty_select_if;
    logic       key_up;
    logic       key_down;
    logic       start;
    logic       game_over;
    logic       level_up;
    logic [2:0] diff;
    logic       tick;
    logic       playing;

    modport master (
        output key_up,
        output key_down,
        output start,
        output game_over,
        output level_up,
        input  diff,
        input  tick,
        input  playing
    );

    modport slave (
        input  key_up,
        input  key_down,
        input  start,
        input  game_over,
        input  level_up,
        output diff,
        output tick,
        output playing
    );
endinterface

// File: rtl/difficulty_select.sv
// Difficulty selector: four levels chosen by up/down buttons while idle,
// auto-advanced by the score logic during play, and a game-speed tick whose
// period halves with every level. PERIOD1 must be a power of two >= 8.
module difficulty_select #(
    parameter int PERIOD1 = 16
) (
    input  logic                clk,
    input  logic                reset,
    difficulty_select_if.slave  bus
);

    localparam int CW = $clog2(PERIOD1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PLAY = 2'd1;
    localparam logic [1:0] ST_OVER = 2'd2;

    // Level is held as 0..3 internally (L1..L4).
    localparam logic [1:0] LVL_MIN = 2'd0;
    localparam logic [1:0] LVL_MAX = 2'd3;

    // Last counter value of a tick period at the given level: (PERIOD1 >> lvl) - 1.
    function automatic logic [CW-1:0] period_last(input logic [1:0] lvl);
        return CW'((PERIOD1 >> lvl) - 1);
    endfunction

    // Thermometer code for the display: L1=000, L2=001, L3=011, L4=111.
    function automatic logic [2:0] thermo(input logic [1:0] lvl);
        logic [2:0] code;
        case (lvl)
            2'd0:    code = 3'b000;
            2'd1:    code = 3'b001;
            2'd2:    code = 3'b011;
            default: code = 3'b111;
        endcase
        return code;
    endfunction

    // Key conditioning: two synchroniser flops, a previous-value flop and a
    // registered rising-edge pulse, so a press acts three edges after the
    // key is first sampled high.
    logic up_s1_q,    up_s1_d;
    logic up_s2_q,    up_s2_d;
    logic up_prev_q,  up_prev_d;
    logic up_press_q, up_press_d;
    logic dn_s1_q,    dn_s1_d;
    logic dn_s2_q,    dn_s2_d;
    logic dn_prev_q,  dn_prev_d;
    logic dn_press_q, dn_press_d;

    // Game state, level and tick generation.
    logic [1:0]    state_q, state_d;
    logic [1:0]    level_q, level_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic          tick_q,  tick_d;

    // Synchronise both keys and detect their rising edges.
    always_comb begin
        up_s1_d    = bus.key_up;
        up_s2_d    = up_s1_q;
        up_prev_d  = up_s2_q;
        up_press_d = up_s2_q & ~up_prev_q;
        dn_s1_d    = bus.key_down;
        dn_s2_d    = dn_s1_q;
        dn_prev_d  = dn_s2_q;
        dn_press_d = dn_s2_q & ~dn_prev_q;
    end

    // Game FSM, level update and tick counter. The counter idles at 0 outside
    // play and restarts whenever the level actually changes during play.
    always_comb begin
        state_d = state_q;
        level_d = level_q;
        cnt_d   = '0;
        tick_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Opposite presses in the same cycle cancel out.
                if (up_press_q && !dn_press_q && level_q != LVL_MAX) begin
                    level_d = level_q + 2'd1;
                end else if (dn_press_q && !up_press_q && level_q != LVL_MIN) begin
                    level_d = level_q - 2'd1;
                end
                if (bus.start) begin
                    state_d = ST_PLAY;
                end
            end
            ST_PLAY: begin
                // game_over takes priority over a coincident level_up.
                if (bus.game_over) begin
                    state_d = ST_OVER;
                end else if (bus.level_up && level_q != LVL_MAX) begin
                    level_d = level_q + 2'd1;
                end else if (cnt_q == period_last(level_q)) begin
                    tick_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_OVER: begin
                if (up_press_q || dn_press_q || bus.start) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset clears everything including the key pipeline.
    always_ff @(posedge clk) begin
        if (reset) begin
            up_s1_q    <= 1'b0;
            up_s2_q    <= 1'b0;
            up_prev_q  <= 1'b0;
            up_press_q <= 1'b0;
            dn_s1_q    <= 1'b0;
            dn_s2_q    <= 1'b0;
            dn_prev_q  <= 1'b0;
            dn_press_q <= 1'b0;
            state_q    <= ST_IDLE;
            level_q    <= LVL_MIN;
            cnt_q      <= '0;
            tick_q     <= 1'b0;
        end else begin
            up_s1_q    <= up_s1_d;
            up_s2_q    <= up_s2_d;
            up_prev_q  <= up_prev_d;
            up_press_q <= up_press_d;
            dn_s1_q    <= dn_s1_d;
            dn_s2_q    <= dn_s2_d;
            dn_prev_q  <= dn_prev_d;
            dn_press_q <= dn_press_d;
            state_q    <= state_d;
            level_q    <= level_d;
            cnt_q      <= cnt_d;
            tick_q     <= tick_d;
        end
    end

    assign bus.diff    = thermo(level_q);
    assign bus.tick    = tick_q;
    assign bus.playing = (state_q == ST_PLAY);

endmodule

// File: tb/tb_difficulty_select.sv
// Bench for difficulty_select: directed scenarios followed by random play,
// every cycle compared against a behavioural model of the game rules.
module tb_difficulty_select;

    localparam int PERIOD1 = 16;

    logic clk;
    logic reset;
    difficulty_select_if bus();

    difficulty_select #(.PERIOD1(PERIOD1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Behavioural model
    localparam int M_IDLE = 0;
    localparam int M_PLAY = 1;
    localparam int M_OVER = 2;

    int     m_mode   = M_IDLE;
    int     m_level  = 1;
    bit     m_tick   = 1'b0;
    longint edge_no  = 0;
    longint anchor   = 0;
    bit     uh[4];   // key_up as sampled 1..4 edges ago (0 = most recent)
    bit     dh[4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance the model by one rising edge using the inputs present at that edge.
    task automatic model_edge();
        bit pu, pd;
        int per;
        edge_no++;
        if (reset) begin
            m_mode  = M_IDLE;
            m_level = 1;
            m_tick  = 1'b0;
            for (int i = 0; i < 4; i++) begin
                uh[i] = 1'b0;
                dh[i] = 1'b0;
            end
            return;
        end
        // A press acts when the key was sampled high 3 edges ago and low 4 edges ago.
        pu = uh[2] && !uh[3];
        pd = dh[2] && !dh[3];
        for (int i = 3; i > 0; i--) begin
            uh[i] = uh[i-1];
            dh[i] = dh[i-1];
        end
        uh[0] = bus.key_up;
        dh[0] = bus.key_down;
        m_tick = 1'b0;
        case (m_mode)
            M_IDLE: begin
                if (pu && !pd && m_level < 4) m_level++;
                else if (pd && !pu && m_level > 1) m_level--;
                if (bus.start) begin
                    m_mode = M_PLAY;
                    anchor = edge_no;
                end
            end
            M_PLAY: begin
                per = PERIOD1 >> (m_level - 1);
                if (bus.game_over) begin
                    m_mode = M_OVER;
                end else if (bus.level_up && m_level < 4) begin
                    m_level++;
                    anchor = edge_no;
                end else if ((edge_no - anchor) % per == 0) begin
                    m_tick = 1'b1;
                end
            end
            default: begin
                if (pu || pd || bus.start) m_mode = M_IDLE;
            end
        endcase
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("diff",    32'(bus.diff),    32'((1 << (m_level - 1)) - 1));
        chk("playing", 32'(bus.playing), 32'(m_mode == M_PLAY));
        chk("tick",    32'(bus.tick),    32'(m_tick));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Count edges until the next tick, bounded; a timeout shows up as a wrong gap.
    task automatic wait_tick(input string tag, input int exp);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (bus.tick !== 1'b1 && n < 64);
        chk(tag, 32'(n), 32'(exp));
    endtask

    task automatic press(input bit up);
        if (up) bus.key_up = 1'b1; else bus.key_down = 1'b1;
        run(3);
        if (up) bus.key_up = 1'b0; else bus.key_down = 1'b0;
        run(3);
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    task automatic pulse_level_up();
        bus.level_up = 1'b1;
        step();
        bus.level_up = 1'b0;
    endtask

    initial begin
        reset         = 1'b1;
        bus.key_up    = 1'b0;
        bus.key_down  = 1'b0;
        bus.start     = 1'b0;
        bus.game_over = 1'b0;
        bus.level_up  = 1'b0;

        // Reset state
        run(3);
        reset = 1'b0;
        chk("reset_diff", 32'(bus.diff), 32'd0);
        chk("reset_playing", 32'(bus.playing), 32'd0);

        // Held up key: one step, three edges after first sample
        bus.key_up = 1'b1;
        run(3);
        chk("hold_before", 32'(bus.diff), 32'b000);
        run(1);
        chk("hold_step", 32'(bus.diff), 32'b001);
        run(6);
        chk("hold_no_repeat", 32'(bus.diff), 32'b001);
        bus.key_up = 1'b0;
        run(2);
        for (int i = 0; i < 3; i++) begin
            bus.key_up = 1'b1;
            run(4);
            bus.key_up = 1'b0;
            run(3);
        end
        chk("up_saturate", 32'(bus.diff), 32'b111);

        // Simultaneous up/down from L2, then down to saturation at L1
        reset = 1'b1;
        step();
        reset = 1'b0;
        press(1'b1);
        run(2);
        chk("l2_reached", 32'(bus.diff), 32'b001);
        bus.key_up   = 1'b1;
        bus.key_down = 1'b1;
        run(5);
        bus.key_up   = 1'b0;
        bus.key_down = 1'b0;
        run(4);
        chk("both_keys", 32'(bus.diff), 32'b001);
        for (int i = 0; i < 4; i++) press(1'b0);
        run(2);
        chk("down_saturate", 32'(bus.diff), 32'b000);

        // Play at L1: 16-cycle ticks, keys ignored
        pulse_start();
        chk("start_playing", 32'(bus.playing), 32'd1);
        bus.key_up = 1'b1;
        wait_tick("gap_l1_first", 16);
        bus.key_up   = 1'b0;
        bus.key_down = 1'b1;
        wait_tick("gap_l1", 16);
        bus.key_down = 1'b0;
        chk("keys_ignored", 32'(bus.diff), 32'b000);

        // Auto-advance during play
        pulse_level_up();
        wait_tick("gap_l2_first", 8);
        wait_tick("gap_l2", 8);
        chk("auto_l2", 32'(bus.diff), 32'b001);
        pulse_level_up();
        wait_tick("gap_l3_first", 4);
        wait_tick("gap_l3", 4);
        chk("auto_l3", 32'(bus.diff), 32'b011);
        pulse_level_up();
        wait_tick("gap_l4_first", 2);
        wait_tick("gap_l4", 2);
        chk("auto_l4", 32'(bus.diff), 32'b111);
        pulse_level_up();
        run(3);
        pulse_level_up();
        run(3);
        chk("auto_saturate", 32'(bus.diff), 32'b111);

        // game_over beats level_up; key press returns to idle with level kept
        bus.game_over = 1'b1;
        bus.level_up  = 1'b1;
        step();
        bus.game_over = 1'b0;
        bus.level_up  = 1'b0;
        chk("over_playing", 32'(bus.playing), 32'd0);
        chk("over_tick", 32'(bus.tick), 32'd0);
        run(5);
        press(1'b0);
        run(2);
        chk("over_exit_level", 32'(bus.diff), 32'b111);
        press(1'b0);
        run(2);
        chk("idle_after_over", 32'(bus.diff), 32'b011);

        // Reset mid-play at L3, then restart ticking
        reset = 1'b1;
        step();
        reset = 1'b0;
        press(1'b1);
        press(1'b1);
        run(2);
        chk("l3_reached", 32'(bus.diff), 32'b011);
        pulse_start();
        run(5);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("midplay_reset_diff", 32'(bus.diff), 32'b000);
        chk("midplay_reset_playing", 32'(bus.playing), 32'd0);
        pulse_start();
        wait_tick("restart_first", 16);
        wait_tick("restart_gap", 16);

        // Random play against the model
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 9) == 0) bus.key_up = ~bus.key_up;
            if ($urandom_range(0, 9) == 0) bus.key_down = ~bus.key_down;
            bus.start     = ($urandom_range(0, 19) == 0);
            bus.game_over = ($urandom_range(0, 39) == 0);
            bus.level_up  = ($urandom_range(0, 24) == 0);
            reset         = ($urandom_range(0, 299) == 0);
            step();
        end
        reset         = 1'b0;
        bus.start     = 1'b0;
        bus.game_over = 1'b0;
        bus.level_up  = 1'b0;
        run(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
